// File: rtl/subleq_mem_responder_pkg.sv
// Shared types and default sizes for the subleq64 memory responder.
package subleq_mem_responder_pkg;

  localparam int unsigned DEF_ADDR_W    = 13;
  localparam int unsigned DEF_DATA_W    = 64;
  localparam int unsigned DEF_RAM_DEPTH = 2 ** DEF_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage : subleq_mem_responder_pkg

// File: rtl/subleq_mem_responder_ram64_sp.sv
// Single-port synchronous word RAM; registered output, old data on read-during-write.
module ram64_sp #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 64
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iData,
  input  logic              iWe,
  output logic [DATA_W-1:0] oQ
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge iClock) begin
    if (iWe) begin
      r_mem[iAddr] <= iData;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_q <= '0;
    end else begin
      r_q <= r_mem[iAddr];
    end
  end

  assign oQ = r_q;

endmodule : ram64_sp

// File: rtl/subleq_mem_responder.sv
// Memory-side responder for the subleq64 core: core bus, host image loader and core hold control.
module subleq_mem_responder
  import subleq_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [ADDR_W-1:0] iAddress,
  input  logic [DATA_W-1:0] iData,
  input  logic              iWren,
  output logic [DATA_W-1:0] oQ,
  input  logic              iLoadStart,
  input  logic              iRunStart,
  input  logic              iLoadValid,
  input  logic [DATA_W-1:0] iLoadData,
  input  logic              iLoadLast,
  output logic              oLoadReady,
  output logic [ADDR_W:0]   oLoadCount,
  output logic              oLoadDone,
  output logic              oCpuHold
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_load_count;
  logic              r_load_done;
  logic              r_load_ready;
  logic              r_cpu_hold;

  logic              w_clr;
  logic              w_xfer;
  logic              w_done_nxt;
  logic              w_ptr_at_max;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_data;
  logic              w_ram_we;

  assign w_ptr_at_max = (r_ptr == {ADDR_W{1'b1}});

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus RAM port ownership: core in RUN, loader in LOAD, read-only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_xfer      = 1'b0;
    w_done_nxt  = 1'b0;
    w_ram_addr  = iAddress;
    w_ram_data  = iData;
    w_ram_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iLoadStart) begin
          w_state_nxt = ST_LOAD;
          w_clr       = 1'b1;
        end else if (iRunStart) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        w_ram_addr = r_ptr;
        w_ram_data = iLoadData;
        w_ram_we   = iLoadValid;
        w_xfer     = iLoadValid;
        if (iLoadValid && (iLoadLast || w_ptr_at_max)) begin
          w_state_nxt = ST_RUN;
          w_done_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        w_ram_we = iWren;
        if (iLoadStart) begin
          w_state_nxt = ST_LOAD;
          w_clr       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pointer holds at the top address so a full-depth load never wraps onto word 0.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_ptr        <= '0;
      r_load_count <= '0;
    end else if (w_clr) begin
      r_ptr        <= '0;
      r_load_count <= '0;
    end else if (w_xfer) begin
      if (!w_ptr_at_max) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
      r_load_count <= r_load_count + CNT_W'(1);
    end
  end

  // Status outputs follow the next state so they line up with the first cycle in it.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_load_done  <= 1'b0;
      r_load_ready <= 1'b0;
      r_cpu_hold   <= 1'b1;
    end else begin
      r_load_done  <= w_done_nxt;
      r_load_ready <= (w_state_nxt == ST_LOAD);
      r_cpu_hold   <= (w_state_nxt != ST_RUN);
    end
  end

  ram64_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .iClock (iClock),
    .iReset (iReset),
    .iAddr  (w_ram_addr),
    .iData  (w_ram_data),
    .iWe    (w_ram_we && !iReset),
    .oQ     (oQ)
  );

  assign oLoadReady = r_load_ready;
  assign oLoadCount = r_load_count;
  assign oLoadDone  = r_load_done;
  assign oCpuHold   = r_cpu_hold;

endmodule : subleq_mem_responder

// File: tb/tb_subleq_mem_responder.sv
// Directed bench for subleq_mem_responder with a 16-word RAM.
module tb_subleq_mem_responder;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 64;

  logic              iClock;
  logic              iReset;
  logic [ADDR_W-1:0] iAddress;
  logic [DATA_W-1:0] iData;
  logic              iWren;
  logic [DATA_W-1:0] oQ;
  logic              iLoadStart;
  logic              iRunStart;
  logic              iLoadValid;
  logic [DATA_W-1:0] iLoadData;
  logic              iLoadLast;
  logic              oLoadReady;
  logic [ADDR_W:0]   oLoadCount;
  logic              oLoadDone;
  logic              oCpuHold;

  int n_pass;
  int n_total;

  subleq_mem_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iAddress   (iAddress),
    .iData      (iData),
    .iWren      (iWren),
    .oQ         (oQ),
    .iLoadStart (iLoadStart),
    .iRunStart  (iRunStart),
    .iLoadValid (iLoadValid),
    .iLoadData  (iLoadData),
    .iLoadLast  (iLoadLast),
    .oLoadReady (oLoadReady),
    .oLoadCount (oLoadCount),
    .oLoadDone  (oLoadDone),
    .oCpuHold   (oCpuHold)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    tick();
    tick();
    n_total++;
    if (oCpuHold !== 1'b1 || oLoadReady !== 1'b0 || oLoadDone !== 1'b0 || oLoadCount !== 5'd0 || oQ !== 64'h0)
      $display("FAIL reset_state hold=%b ready=%b done=%b count=%0d q=%h", oCpuHold, oLoadReady, oLoadDone, oLoadCount, oQ);
    else n_pass++;
    iReset = 1'b0;
  endtask

  task automatic test_load_three();
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    n_total++;
    if (oLoadReady !== 1'b1 || oCpuHold !== 1'b1)
      $display("FAIL load_entry ready=%b hold=%b exp 1/1", oLoadReady, oCpuHold);
    else n_pass++;
    iLoadValid = 1'b1;
    iLoadData  = 64'h11;
    tick();
    iLoadData  = 64'h22;
    tick();
    n_total++;
    if (oLoadCount !== 5'd2 || oLoadDone !== 1'b0 || oCpuHold !== 1'b1)
      $display("FAIL load_mid count=%0d done=%b hold=%b exp 2/0/1", oLoadCount, oLoadDone, oCpuHold);
    else n_pass++;
    iLoadData = 64'h33;
    iLoadLast = 1'b1;
    tick();
    iLoadValid = 1'b0;
    iLoadLast  = 1'b0;
    n_total++;
    if (oLoadCount !== 5'd3 || oLoadDone !== 1'b1 || oCpuHold !== 1'b0 || oLoadReady !== 1'b0)
      $display("FAIL load_end count=%0d done=%b hold=%b ready=%b exp 3/1/0/0", oLoadCount, oLoadDone, oCpuHold, oLoadReady);
    else n_pass++;
    iAddress = 4'd0;
    tick();
    n_total++;
    if (oLoadDone !== 1'b0 || oLoadCount !== 5'd3)
      $display("FAIL done_pulse done=%b count=%0d exp 0/3", oLoadDone, oLoadCount);
    else n_pass++;
    n_total++;
    if (oQ !== 64'h11) $display("FAIL rd_addr0 got %h exp %h", oQ, 64'h11);
    else n_pass++;
    iAddress = 4'd1;
    tick();
    n_total++;
    if (oQ !== 64'h22) $display("FAIL rd_addr1 got %h exp %h", oQ, 64'h22);
    else n_pass++;
    iAddress = 4'd2;
    tick();
    n_total++;
    if (oQ !== 64'h33) $display("FAIL rd_addr2 got %h exp %h", oQ, 64'h33);
    else n_pass++;
  endtask

  task automatic test_read_during_write();
    iAddress = 4'd7;
    iData    = 64'hAA;
    iWren    = 1'b1;
    tick();
    iData = 64'h5;
    tick();
    iWren = 1'b0;
    n_total++;
    if (oQ !== 64'hAA) $display("FAIL rdw_old got %h exp %h", oQ, 64'hAA);
    else n_pass++;
    tick();
    n_total++;
    if (oQ !== 64'h5) $display("FAIL rdw_new got %h exp %h", oQ, 64'h5);
    else n_pass++;
  endtask

  task automatic test_full_depth();
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    n_total++;
    if (oCpuHold !== 1'b1 || oLoadCount !== 5'd0 || oLoadReady !== 1'b1)
      $display("FAIL run_to_load hold=%b count=%0d ready=%b exp 1/0/1", oCpuHold, oLoadCount, oLoadReady);
    else n_pass++;
    iLoadValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iLoadData = 64'h100 + 64'(i);
      tick();
    end
    n_total++;
    if (oLoadCount !== 5'd16 || oLoadDone !== 1'b1 || oCpuHold !== 1'b0 || oLoadReady !== 1'b0)
      $display("FAIL full_end count=%0d done=%b hold=%b ready=%b exp 16/1/0/0", oLoadCount, oLoadDone, oCpuHold, oLoadReady);
    else n_pass++;
    iLoadData = 64'hDEAD;
    tick();
    iLoadValid = 1'b0;
    n_total++;
    if (oLoadCount !== 5'd16 || oLoadReady !== 1'b0)
      $display("FAIL extra_word count=%0d ready=%b exp 16/0", oLoadCount, oLoadReady);
    else n_pass++;
    iAddress = 4'd0;
    tick();
    n_total++;
    if (oQ !== 64'h100) $display("FAIL full_addr0 got %h exp %h", oQ, 64'h100);
    else n_pass++;
    iAddress = 4'd15;
    tick();
    n_total++;
    if (oQ !== 64'h10F) $display("FAIL full_addr15 got %h exp %h", oQ, 64'h10F);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    iLoadValid = 1'b1;
    iLoadData  = 64'hA0;
    tick();
    iLoadData  = 64'hA1;
    tick();
    iLoadValid = 1'b0;
    iReset     = 1'b1;
    tick();
    iReset = 1'b0;
    n_total++;
    if (oCpuHold !== 1'b1 || oLoadCount !== 5'd0 || oLoadReady !== 1'b0 || oLoadDone !== 1'b0)
      $display("FAIL mid_reset hold=%b count=%0d ready=%b done=%b exp 1/0/0/0", oCpuHold, oLoadCount, oLoadReady, oLoadDone);
    else n_pass++;
    iAddress = 4'd0;
    tick();
    n_total++;
    if (oQ !== 64'hA0) $display("FAIL kept_addr0 got %h exp %h", oQ, 64'hA0);
    else n_pass++;
    iAddress = 4'd1;
    tick();
    n_total++;
    if (oQ !== 64'hA1) $display("FAIL kept_addr1 got %h exp %h", oQ, 64'hA1);
    else n_pass++;
    iAddress = 4'd2;
    tick();
    n_total++;
    if (oQ !== 64'h102) $display("FAIL untouched_addr2 got %h exp %h", oQ, 64'h102);
    else n_pass++;
    n_total++;
    if (oCpuHold !== 1'b1) $display("FAIL idle_hold got %b exp 1", oCpuHold);
    else n_pass++;
  endtask

  task automatic test_write_gating();
    iAddress = 4'd3;
    iData    = 64'hBAD;
    iWren    = 1'b1;
    tick();
    tick();
    iWren = 1'b0;
    tick();
    n_total++;
    if (oQ !== 64'h103) $display("FAIL idle_wren got %h exp %h", oQ, 64'h103);
    else n_pass++;
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    iWren      = 1'b1;
    tick();
    tick();
    iWren      = 1'b0;
    iLoadValid = 1'b1;
    iLoadLast  = 1'b1;
    iLoadData  = 64'hC0;
    tick();
    iLoadValid = 1'b0;
    iLoadLast  = 1'b0;
    n_total++;
    if (oCpuHold !== 1'b0 || oLoadCount !== 5'd1)
      $display("FAIL short_load hold=%b count=%0d exp 0/1", oCpuHold, oLoadCount);
    else n_pass++;
    iAddress = 4'd3;
    tick();
    n_total++;
    if (oQ !== 64'h103) $display("FAIL load_wren got %h exp %h", oQ, 64'h103);
    else n_pass++;
    iAddress   = 4'd0;
    iLoadValid = 1'b1;
    iLoadData  = 64'hEE;
    tick();
    n_total++;
    if (oLoadReady !== 1'b0 || oQ !== 64'hC0)
      $display("FAIL run_valid ready=%b q=%h exp 0/%h", oLoadReady, oQ, 64'hC0);
    else n_pass++;
    tick();
    iLoadValid = 1'b0;
    iAddress   = 4'd1;
    tick();
    n_total++;
    if (oQ !== 64'hA1 || oLoadCount !== 5'd1)
      $display("FAIL run_drop q=%h count=%0d exp %h/1", oQ, oLoadCount, 64'hA1);
    else n_pass++;
  endtask

  task automatic test_priority();
    iReset = 1'b1;
    tick();
    iReset     = 1'b0;
    iLoadStart = 1'b1;
    iRunStart  = 1'b1;
    tick();
    iLoadStart = 1'b0;
    iRunStart  = 1'b0;
    n_total++;
    if (oLoadReady !== 1'b1 || oCpuHold !== 1'b1)
      $display("FAIL start_priority ready=%b hold=%b exp 1/1", oLoadReady, oCpuHold);
    else n_pass++;
    iLoadValid = 1'b1;
    iLoadLast  = 1'b1;
    iLoadData  = 64'hD0;
    tick();
    iLoadValid = 1'b0;
    iLoadLast  = 1'b0;
    iLoadStart = 1'b1;
    tick();
    iLoadStart = 1'b0;
    n_total++;
    if (oCpuHold !== 1'b1 || oLoadCount !== 5'd0 || oLoadReady !== 1'b1)
      $display("FAIL reload hold=%b count=%0d ready=%b exp 1/0/1", oCpuHold, oLoadCount, oLoadReady);
    else n_pass++;
    iReset = 1'b1;
    tick();
    iReset    = 1'b0;
    iRunStart = 1'b1;
    tick();
    iRunStart = 1'b0;
    n_total++;
    if (oCpuHold !== 1'b0 || oLoadReady !== 1'b0)
      $display("FAIL run_start hold=%b ready=%b exp 0/0", oCpuHold, oLoadReady);
    else n_pass++;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    iReset     = 1'b1;
    iAddress   = '0;
    iData      = '0;
    iWren      = 1'b0;
    iLoadStart = 1'b0;
    iRunStart  = 1'b0;
    iLoadValid = 1'b0;
    iLoadData  = '0;
    iLoadLast  = 1'b0;
    test_reset();
    test_load_three();
    test_read_during_write();
    test_full_depth();
    test_reset_mid_load();
    test_write_gating();
    test_priority();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_subleq_mem_responder

// File: doc/subleq_mem_responder.md
Name: subleq_mem_responder

Overview:
- Memory-side responder for the subleq64 core's 64-bit word bus.
- Serves the core's address/data/write-enable requests with a fixed 1-cycle registered read latency, the same timing the core's 4-phase sequencer expects.
- Adds a host load port with a valid/ready handshake, so a program image can be streamed into memory while the core is held in reset.
- Sits between the core, the on-chip word RAM and the host/loader logic.

Parameters:
- ADDR_W, 13, word address width; memory depth is 2**ADDR_W.
- DATA_W, 64, word width.

Ports:
- iClock  in  1  system clock; all state changes on its rising edge.
- iReset  in  1  synchronous, active-high reset.
- iAddress  in  ADDR_W  core request address.
- iData  in  DATA_W  core write data.
- iWren  in  1  core write enable.
- oQ  out  DATA_W  registered read data.
- iLoadStart  in  1  request to enter load mode.
- iRunStart  in  1  request to release the core from IDLE without loading.
- iLoadValid  in  1  host word valid.
- iLoadData  in  DATA_W  host word.
- iLoadLast  in  1  marks the final word; qualified by iLoadValid.
- oLoadReady  out  1  loader accepts a word this cycle.
- oLoadCount  out  ADDR_W+1  number of words written in the current or most recent load.
- oLoadDone  out  1  one-cycle pulse when a load completes.
- oCpuHold  out  1  drives the core's iReset; high while the core must not run.

Behaviour:

Reset (iReset=1 at a clock edge):
- State goes to IDLE.
- oCpuHold=1, oLoadReady=0, oLoadDone=0, oLoadCount=0, oQ=0.
- RAM contents are not cleared.
- Reset mid-load aborts the load immediately. Words already written stay in RAM.

State machine, 2-bit encoding (IDLE=0, LOAD=1, RUN=2):

IDLE:
- oCpuHold=1, oLoadReady=0.
- iLoadStart goes to LOAD; the write pointer and oLoadCount are cleared.
- Otherwise iRunStart goes to RUN.
- iLoadStart has priority over iRunStart when both are high.

LOAD:
- oCpuHold=1, oLoadReady=1.
- A word transfers when iLoadValid=1, because oLoadReady=1 in this state.
- On each transfer: RAM[ptr] <= iLoadData, ptr <= ptr+1, oLoadCount <= oLoadCount+1.
- If iLoadLast=1 or ptr==2**ADDR_W-1 on a transfer, the next state is RUN and oLoadDone pulses high for the next cycle only.
- A full-depth load without iLoadLast therefore ends at oLoadCount = 2**ADDR_W. The pointer never wraps.
- iLoadStart is ignored while in LOAD.

RUN:
- oCpuHold=0 from the first cycle in RUN.
- The core owns the RAM port: iWren=1 writes iData to RAM[iAddress].
- iLoadStart goes to LOAD and clears the pointer and count. oCpuHold rises in that same transition, i.e. it is high on the first LOAD cycle.
- Words presented with iLoadValid while not in LOAD are dropped, since oLoadReady=0.

RAM port mux:
- In RUN the core drives the port (address = iAddress, data = iData, we = iWren).
- In LOAD the loader drives it (address = ptr, data = iLoadData, we = iLoadValid).
- In IDLE the port is read-only at iAddress.
- Core iWren is ignored in IDLE and LOAD.

Read timing:
- oQ <= RAM[selected address] at every clock edge, giving 1-cycle latency.
- Read during a write to the same address returns the OLD data; new data is visible on the following read.
- In LOAD, oQ returns the old contents of RAM[ptr].

Width rules:
- ptr is ADDR_W bits; oLoadCount is ADDR_W+1 bits, so a full-depth load reports exactly 2**ADDR_W.

Decomposition:
- Shared package holds: the state typedef and encodings (IDLE/LOAD/RUN), the ADDR_W/DATA_W defaults, and a RAM depth constant.
- One sub-module, ram64_sp: single-port synchronous RAM with registered output and old-data read-during-write, inferable on the target FPGA.
- The FSM, pointer and mux stay in the top.

Test Plan:
1. Reset, then iLoadStart, then 3 words 0x11, 0x22, 0x33 with iLoadLast on the third -> oLoadCount=3; oLoadDone is a single pulse; oCpuHold falls the cycle after the last word; in RUN, reads of addresses 0, 1, 2 give 0x11, 0x22, 0x33 one cycle after each address.
2. In RUN, write 0x5 to address 7, read address 7 in the same cycle -> old value; read address 7 in the next cycle -> 0x5.
3. Stream 2**ADDR_W words (ADDR_W=4, 16 words) with no iLoadLast -> oLoadCount=16, transition to RUN, address 0 not overwritten by a 17th word.
4. iReset after 2 of 5 words during LOAD -> state IDLE, oCpuHold=1, oLoadCount=0, RAM addresses 0 and 1 hold the loaded words.
5. iWren=1 at address 3 while in IDLE or LOAD -> RAM[3] unchanged; iLoadValid asserted in RUN -> no write, oLoadReady=0.
6. iLoadStart and iRunStart asserted together in IDLE -> LOAD entered; iLoadStart asserted in RUN -> oCpuHold=1 on the next cycle and oLoadCount cleared to 0.
